// File: rtl/zebra_stop_filter.sv
// zebra_stop_filter: debounced, hysteretic zebra-crossing stop request.
// Optional stall watchdog is built when ZEBRA_STOP_WATCHDOG_EN is defined.
module zebra_stop_filter #(
    parameter int CONFIRM_N       = 3,
    parameter int RELEASE_M       = 4,
    parameter int MIN_STRIPES     = 4,
    parameter int MIN_HOLD_CYCLES = 25000000,
    parameter int TIMEOUT_CYCLES  = 50000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       detection_valid,
    input  logic       crossing_detected,
    input  logic [7:0] stripe_count,
    input  logic       clear,
    output logic       stop,
    output logic       stop_rise,
    output logic [1:0] state,
    output logic [3:0] run_cnt,
    output logic       stale
);

    localparam int            TW        = $clog2(MIN_HOLD_CYCLES + 1);
    localparam logic [TW-1:0] HOLD_LOAD = TW'(MIN_HOLD_CYCLES - 1);
    localparam logic [7:0]    MIN_SC    = 8'(MIN_STRIPES);
    localparam logic [3:0]    CN        = 4'(CONFIRM_N);
    localparam logic [3:0]    RM        = 4'(RELEASE_M);

    if (CONFIRM_N < 1 || CONFIRM_N > 15 || RELEASE_M < 1 || RELEASE_M > 15 ||
        MIN_HOLD_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("zebra_stop_filter: parameter out of range");
    end

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_CONFIRM = 2'b01,
        S_STOP    = 2'b10,
        S_RELEASE = 2'b11
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [3:0]    r_run_cnt;
    logic [3:0]    w_run_nxt;
    logic [3:0]    w_run_inc;
    logic [TW-1:0] r_hold;
    logic [TW-1:0] w_hold_nxt;
    logic          r_stop;
    logic          r_stop_rise;
    logic          w_stop_nxt;
    logic          w_pos;
    logic          w_load;
    logic          w_timeout;

    assign w_pos     = crossing_detected && (stripe_count >= MIN_SC);
    assign w_run_inc = r_run_cnt + 4'd1;

`ifdef ZEBRA_STOP_WATCHDOG_EN
    localparam int            WW      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WW-1:0] WD_LOAD = WW'(TIMEOUT_CYCLES - 1);

    logic [WW-1:0] r_wd;
    logic          r_stale;

    // Counter saturates at zero so the forced flush persists until a strobe.
    assign w_timeout = (r_wd == '0) && !detection_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wd    <= WD_LOAD;
            r_stale <= 1'b0;
        end else if (clear || detection_valid) begin
            r_wd    <= WD_LOAD;
            r_stale <= 1'b0;
        end else begin
            if (r_wd != '0) r_wd <= r_wd - WW'(1);
            if (w_timeout) r_stale <= 1'b1;
        end
    end

    assign stale = r_stale;
`else
    assign w_timeout = 1'b0;
    assign stale     = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_run_nxt   = r_run_cnt;
        w_load      = 1'b0;
        if (clear || w_timeout) begin
            w_state_nxt = S_IDLE;
            w_run_nxt   = '0;
        end else if (detection_valid) begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_pos) begin
                        if (CN == 4'd1) begin
                            w_state_nxt = S_STOP;
                            w_load      = 1'b1;
                        end else begin
                            w_state_nxt = S_CONFIRM;
                            w_run_nxt   = 4'd1;
                        end
                    end
                end
                S_CONFIRM: begin
                    if (!w_pos) begin
                        w_state_nxt = S_IDLE;
                        w_run_nxt   = '0;
                    end else if (w_run_inc == CN) begin
                        w_state_nxt = S_STOP;
                        w_run_nxt   = '0;
                        w_load      = 1'b1;
                    end else begin
                        w_run_nxt = w_run_inc;
                    end
                end
                S_STOP: begin
                    if (!w_pos && r_hold == '0) begin
                        if (RM == 4'd1) begin
                            w_state_nxt = S_IDLE;
                        end else begin
                            w_state_nxt = S_RELEASE;
                            w_run_nxt   = 4'd1;
                        end
                    end
                end
                S_RELEASE: begin
                    if (w_pos) begin
                        w_state_nxt = S_STOP;
                        w_run_nxt   = '0;
                    end else if (w_run_inc == RM) begin
                        w_state_nxt = S_IDLE;
                        w_run_nxt   = '0;
                    end else begin
                        w_run_nxt = w_run_inc;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_run_nxt   = '0;
                end
            endcase
        end

        if (clear || w_timeout) begin
            w_hold_nxt = '0;
        end else if (w_load) begin
            w_hold_nxt = HOLD_LOAD;
        end else if (r_hold != '0) begin
            w_hold_nxt = r_hold - TW'(1);
        end else begin
            w_hold_nxt = r_hold;
        end

        w_stop_nxt = w_state_nxt[1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_run_cnt   <= '0;
            r_hold      <= '0;
            r_stop      <= 1'b0;
            r_stop_rise <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_run_cnt   <= w_run_nxt;
            r_hold      <= w_hold_nxt;
            r_stop      <= w_stop_nxt;
            r_stop_rise <= w_stop_nxt & ~r_stop;
        end
    end

    assign stop      = r_stop;
    assign stop_rise = r_stop_rise;
    assign state     = r_state;
    assign run_cnt   = r_run_cnt;

endmodule
